// File: rtl/regfile_wb_pkg.sv
// Shared register-file constants and helpers, also used by the destination-select mux and the controller.
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WR_CNT_W   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_LINK = 5'd31;

  // A write commits only for a real destination; r0 is a sink and out-of-range slots do not exist.
  // The leading 'we &&' keeps an undriven address harmless while no write is requested.
  function automatic logic wr_ok(input logic we, input reg_addr_t addr, input int nregs);
    return we && (addr != REG_ZERO) && (int'(addr) < nregs);
  endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Write-back / operand-read bus of the register file; master drives addresses and write data.
interface regfile_wb_if
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                we;
  reg_addr_t           waddr;
  logic [DATA_W-1:0]   wdata;
  reg_addr_t           raddr1;
  reg_addr_t           raddr2;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  reg_addr_t           dbg_addr;
  logic [DATA_W-1:0]   dbg_data;
  logic [WR_CNT_W-1:0] wr_count;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data, wr_count
  );
endinterface

// File: rtl/regfile_wb_rport.sv
// One combinational read port: address decode, r0 forced to zero, optional same-cycle write-through.
module regfile_rport
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic [NREGS-1:0][DATA_W-1:0] mem,
  input  reg_addr_t                    raddr,
  input  logic                         byp_vld,
  input  reg_addr_t                    byp_addr,
  input  logic [DATA_W-1:0]            byp_data,
  output logic [DATA_W-1:0]            rdata
);

  always_comb begin
    rdata = '0;
    if (raddr == REG_ZERO)                       rdata = '0;
    else if (byp_vld && (raddr == byp_addr))     rdata = byp_data;
    else if (int'(raddr) < NREGS)                rdata = mem[raddr];
  end

endmodule

// File: rtl/regfile_wb.sv
// Register file with write-back port, three read ports and a committed-write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_wb_if.slave  bus
);

  localparam int NPORTS = 3;

  logic [NREGS-1:0][DATA_W-1:0]        mem;
  logic [WR_CNT_W-1:0]                 wr_cnt;
  logic                                wr_commit;
  logic                                byp_vld;
  logic [NPORTS-1:0][REG_ADDR_W-1:0]   rd_addr;
  logic [NPORTS-1:0][DATA_W-1:0]       rd_data;

  // Reset dominates: a write presented while rst_n is low neither lands nor forwards.
  assign wr_commit = rst_n && wr_ok(bus.we, bus.waddr, NREGS);

`ifdef REGFILE_BYPASS_EN
  assign byp_vld = wr_commit;
`else
  assign byp_vld = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_cnt <= '0;
    end else if (wr_commit) begin
      mem[bus.waddr] <= bus.wdata;
      wr_cnt         <= wr_cnt + 1'b1;
    end
  end

  assign rd_addr = {bus.dbg_addr, bus.raddr2, bus.raddr1};

  for (genvar g = 0; g < NPORTS; g++) begin : g_rport
    regfile_rport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
    ) u_rport (
      .mem      (mem),
      .raddr    (rd_addr[g]),
      .byp_vld  (byp_vld),
      .byp_addr (bus.waddr),
      .byp_data (bus.wdata),
      .rdata    (rd_data[g])
    );
  end

  assign bus.rdata1   = rd_data[0];
  assign bus.rdata2   = rd_data[1];
  assign bus.dbg_data = rd_data[2];
  assign bus.wr_count = wr_cnt;

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized scoreboard bench for regfile_wb against an array/counter reference model.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dbg;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_if #(.DATA_W(32)) bus ();

  regfile_wb #(.DATA_W(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t        q[$];
  logic [31:0] ref_mem[32];
  logic [15:0] ref_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] ref_rd(input logic [4:0] a, input logic w,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (BYP && w && (wa == a)) return wd;
    return ref_mem[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    bus.we = w; bus.waddr = wa; bus.wdata = wd;
    bus.raddr1 = a1; bus.raddr2 = a2; bus.dbg_addr = ad;
  endtask

  // One clock of stimulus; the model applies the write after recording what this cycle should read.
  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                       input bit chk);
    exp_t e;
    @(negedge clk); #1;
    drive(w, wa, wd, a1, a2, ad);
    if (chk) begin
      e.r1  = ref_rd(a1, w, wa, wd);
      e.r2  = ref_rd(a2, w, wa, wd);
      e.dbg = ref_rd(ad, w, wa, wd);
      e.cnt = ref_cnt;
      q.push_back(e);
    end
    if (w && wa != 5'd0) begin
      ref_mem[wa] = wd;
      ref_cnt     = ref_cnt + 16'd1;
    end
  endtask

  // Assert reset mid-cycle; everything must read zero before the next edge.
  task automatic rst_cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    exp_t e;
    @(negedge clk); #1;
    drive(w, wa, wd, a1, a2, ad);
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    ref_cnt = 16'h0;
    e.r1 = 32'h0; e.r2 = 32'h0; e.dbg = 32'h0; e.cnt = 16'h0;
    q.push_back(e);
  endtask

  task automatic release_rst();
    @(negedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
  endtask

  // Monitor: read ports are combinational, so every pushed cycle is sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rdata1",   bus.rdata1,   e.r1);
        check("rdata2",   bus.rdata2,   e.r2);
        check("dbg_data", bus.dbg_data, e.dbg);
        check("wr_count", {16'h0, bus.wr_count}, {16'h0, e.cnt});
      end
    end
  end

  initial begin
    logic [4:0]  wa, a1, a2, ad;
    logic [31:0] wd;
    logic        w;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    ref_cnt = 16'h0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Reset held; a write during reset is lost.
    rst_cycle(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3, 5'd3);
    release_rst();

    // All registers zero after reset.
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i), 1'b1);

    // First write after reset, then read back.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 1'b1);

    // r0 write is discarded and not counted.
    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd0, 1'b1);

    // Link register write with same-cycle read.
    cycle(1'b1, 5'd31, 32'h00400008, 5'd31, 5'd31, 5'd31, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 5'd31, 5'd5, 5'd31, 1'b1);

    // Undriven waddr without we must not disturb anything.
    cycle(1'b0, 5'bxxxxx, 32'hFFFFFFFF, 5'd5, 5'd31, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd1, 1'b1);

    // Random traffic with frequent address aliasing across ports.
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom();
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      ad = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      cycle(w, wa, wd, a1, a2, ad, 1'b1);
    end

    // Asynchronous reset mid-cycle clears data and count immediately.
    cycle(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b1);
    rst_cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    release_rst();
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd31, 5'd5, 1'b1);

    // Counter wrap: 65535 unchecked writes, then one more.
    for (int n = 0; n < 65535; n++)
      cycle(1'b1, 5'($urandom_range(1, 31)), $urandom(), 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd17, 5'd31, 1'b1);
    cycle(1'b1, 5'd12, 32'h0BADC0DE, 5'd12, 5'd0, 5'd12, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 5'd0, 1'b1);

    @(negedge clk); @(negedge clk); #3;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers; address width is fixed at 5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 we  input  1  write request for the current instruction.
REQ-006 waddr  input  5  destination register from the destination-select mux (rt, rd or 5'b11111 for link).
REQ-007 wdata  input  DATA_W  write-back data (ALU result, load data or PC+4).
REQ-008 raddr1 / raddr2  input  5 each  source register addresses (rs, rt).
REQ-009 rdata1 / rdata2  output  DATA_W each  source operand data.
REQ-010 dbg_addr  input  5  debug/test read address.
REQ-011 dbg_data  output  DATA_W  debug read data.
REQ-012 wr_count  output  16  count of committed writes since reset.

Function
REQ-013 Array SHALL hold NREGS registers of DATA_W bits; register 0 reads as zero always.
REQ-014 Write SHALL commit at the rising clk edge when we=1 and waddr!=0; the new value is visible on all read ports from the next cycle.
REQ-015 Write with waddr=0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-016 Read ports SHALL be combinational from the array: zero cycles of latency from raddr to rdata.
REQ-017 rdata1, rdata2 and dbg_data SHALL be independent; any combination of equal addresses SHALL return identical data.
REQ-018 wr_count SHALL increment by 1 per committed write and wrap from 16'hFFFF to 16'h0000.
REQ-019 waddr=5'b11111 SHALL be a normal write to register 31; no special casing.
REQ-020 X or Z on waddr while we=0 SHALL NOT alter any register.

Reset
REQ-021 While rst_n=0, all registers SHALL be zero and wr_count SHALL be zero, asynchronously.
REQ-022 Reset asserted in the same cycle as a write SHALL win; the write SHALL be lost.
REQ-023 After rst_n deasserts, the first write SHALL be accepted at the first rising edge that sees we=1.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN compiled in: when we=1, waddr!=0 and a read address equals waddr, that port SHALL return wdata in the same cycle (write-through), on rdata1, rdata2 and dbg_data.
REQ-025 Macro REGFILE_BYPASS_EN absent: read ports SHALL return the pre-write array value in the write cycle, as specified in REQ-014.
REQ-026 Register 0 SHALL read as zero regardless of REGFILE_BYPASS_EN.

Structure
REQ-027 Shared package SHALL hold REG_ADDR_W=5, REG_ZERO=5'd0 and REG_LINK=5'd31, which the destination-select mux and the controller also use.
REQ-028 One sub-module regfile_rport (one address-decode/bypass read port) SHALL be instantiated three times; the array and wr_count SHALL remain in regfile_wb.

Verification
REQ-029 Reset then read all 32 addresses -> all return 0, wr_count=0.
REQ-030 we=1, waddr=5, wdata=32'hDEADBEEF; next cycle raddr1=5 -> rdata1=32'hDEADBEEF, wr_count=1.
REQ-031 we=1, waddr=0, wdata=32'h12345678 -> raddr2=0 returns 0, wr_count unchanged.
REQ-032 Same-cycle write waddr=31, wdata=32'h00400008 with raddr1=31 -> with REGFILE_BYPASS_EN rdata1=32'h00400008 that cycle; without it, the old value that cycle and the new value the next cycle.
REQ-033 Write reg 7=32'hA5A5A5A5; assert rst_n=0 mid-cycle -> reg 7 and wr_count are 0 immediately, before the next edge.
REQ-034 Preload wr_count to 16'hFFFF via 65535 writes, then one more write -> wr_count=16'h0000.
